// File: rtl/tse_txfifo_mac_rd.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tse_txfifo_mac_rd
// Brief    : MAC-clock read side of the TSE transmit FIFO. Streams frame
//            entries to the MAC, supports retry rewind and flush, and
//            publishes a committed read pointer back to the write side.
// Revision : 1.0 - initial release
// ============================================================================
module tse_txfifo_mac_rd #(
    parameter int TABITS  = 12,
    parameter int DWIDTH  = 32,
    parameter int BEBITS  = $clog2(DWIDTH/8),
    parameter int ENTRY_W = DWIDTH + BEBITS + 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [TABITS:0]     wr_ptr_in,
    input  logic                wr_ptr_upd,
    input  logic [TABITS:0]     start_thresh,
    output logic                rd_en,
    output logic [TABITS-1:0]   rd_addr,
    input  logic [ENTRY_W-1:0]  rd_data,
    output logic [DWIDTH-1:0]   tx_data,
    output logic [BEBITS-1:0]   tx_bcnt,
    output logic                tx_sof,
    output logic                tx_eof,
    output logic                tx_err,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic                tx_retry,
    input  logic                tx_flush,
    output logic                tx_underrun,
    output logic [TABITS:0]     rd_ptr_out,
    output logic                rd_ptr_upd
);

    localparam int c_eofBit = DWIDTH + BEBITS;
    localparam int c_sofBit = DWIDTH + BEBITS + 1;
    localparam int c_errBit = DWIDTH + BEBITS + 2;

    localparam logic [1:0] c_stIdle    = 2'd0;
    localparam logic [1:0] c_stXfer    = 2'd1;
    localparam logic [1:0] c_stDiscard = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_nextState;

    logic [1:0]         r_updSync;
    logic               r_updPrev;
    logic [TABITS:0]    r_wrPtrS;
    logic [TABITS:0]    r_rdPtr;
    logic [TABITS:0]    r_frameStart;
    logic [TABITS:0]    r_rdPtrOut;
    logic               r_rdPtrUpd;

    logic [ENTRY_W-1:0] r_buf0;
    logic [ENTRY_W-1:0] r_buf1;
    logic [1:0]         r_bufCnt;
    logic               r_inflight;
    logic               r_eofSeen;
    logic               r_firstWord;
    logic               r_underPrev;

    logic [TABITS:0]    w_occ;
    logic               w_empty;
    logic               w_inXfer;
    logic               w_inDiscard;
    logic               w_txValid;
    logic               w_accept;
    logic               w_eofAccept;
    logic               w_eofReturning;
    logic               w_eofKnown;
    logic               w_retry;
    logic               w_flush;
    logic               w_flushCommit;
    logic               w_discardDone;
    logic               w_commit;
    logic               w_start;
    logic               w_room;
    logic               w_push;
    logic               w_underCond;

    assign w_occ       = r_wrPtrS - r_rdPtr;
    assign w_empty     = (w_occ == '0);
    assign w_inXfer    = (r_state == c_stXfer);
    assign w_inDiscard = (r_state == c_stDiscard);

    assign w_txValid   = w_inXfer & (r_bufCnt != 2'd0);
    assign w_accept    = w_txValid & tx_ready;
    assign w_eofAccept = w_accept & r_buf0[c_eofBit];

    // RAM output is visible the cycle after issue, so an eof coming back
    // blocks further issue combinationally and nothing is read past the frame.
    assign w_eofReturning = r_inflight & rd_data[c_eofBit];
    assign w_eofKnown     = r_eofSeen | w_eofReturning;

    // Eof acceptance outranks retry; retry outranks flush.
    assign w_retry       = w_inXfer & tx_retry & ~w_eofAccept;
    assign w_flush       = w_inXfer & tx_flush & ~tx_retry & ~w_eofAccept;
    assign w_flushCommit = w_flush & w_eofKnown;
    assign w_discardDone = w_inDiscard & w_eofReturning;
    assign w_commit      = w_eofAccept | w_flushCommit | w_discardDone;

    assign w_start = (r_state == c_stIdle) & ~w_empty & (w_occ >= start_thresh);
    assign w_room  = ({1'b0, r_bufCnt} + {2'b00, r_inflight}) < 3'd2;
    assign w_push  = r_inflight & w_inXfer & ~w_retry & ~w_flush & ~w_eofAccept;

    assign w_underCond = w_inXfer & (r_bufCnt == 2'd0) & ~r_inflight & w_empty & ~r_eofSeen;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_stIdle;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_stIdle: begin
                if (w_start) begin
                    w_nextState = c_stXfer;
                end
            end
            c_stXfer: begin
                if (w_eofAccept || w_retry || w_flushCommit) begin
                    w_nextState = c_stIdle;
                end else if (w_flush) begin
                    w_nextState = c_stDiscard;
                end
            end
            c_stDiscard: begin
                if (w_eofReturning) begin
                    w_nextState = c_stIdle;
                end
            end
            default: begin
                w_nextState = c_stIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------------
    always_comb begin
        rd_en       = 1'b0;
        tx_valid    = w_txValid;
        tx_underrun = w_underCond & ~r_underPrev;
        if ((w_inXfer || w_inDiscard) && !w_empty && w_room && !w_eofKnown
            && !w_retry && !w_flush) begin
            rd_en = 1'b1;
        end
    end

    assign rd_addr    = r_rdPtr[TABITS-1:0];
    assign tx_data    = r_buf0[DWIDTH-1:0];
    assign tx_bcnt    = r_buf0[DWIDTH +: BEBITS];
    assign tx_sof     = r_buf0[c_sofBit];
    assign tx_eof     = r_buf0[c_eofBit];
    // A sof appearing after the first word means a corrupted frame boundary.
    assign tx_err     = r_buf0[c_errBit] | (r_buf0[c_sofBit] & ~r_firstWord);
    assign rd_ptr_out = r_rdPtrOut;
    assign rd_ptr_upd = r_rdPtrUpd;

    // ------------------------------------------------------------------------
    // Write-pointer synchronizer: 2 flops plus edge-detect register.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_updSync <= 2'b00;
            r_updPrev <= 1'b0;
            r_wrPtrS  <= '0;
        end else begin
            r_updSync <= {r_updSync[0], wr_ptr_upd};
            r_updPrev <= r_updSync[1];
            if (r_updSync[1] ^ r_updPrev) begin
                r_wrPtrS <= wr_ptr_in;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pointers, commit and frame tracking
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdPtr      <= '0;
            r_frameStart <= '0;
            r_rdPtrOut   <= '0;
            r_rdPtrUpd   <= 1'b0;
            r_inflight   <= 1'b0;
            r_eofSeen    <= 1'b0;
            r_firstWord  <= 1'b0;
            r_underPrev  <= 1'b0;
        end else begin
            r_inflight  <= rd_en;
            r_underPrev <= w_underCond;

            if (w_retry) begin
                r_rdPtr <= r_frameStart;
            end else if (rd_en) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end

            if (w_start) begin
                r_frameStart <= r_rdPtr;
                r_firstWord  <= 1'b1;
            end else if (w_accept) begin
                r_firstWord  <= 1'b0;
            end

            if (w_commit || w_retry || w_flush) begin
                r_eofSeen <= 1'b0;
            end else if (w_eofReturning) begin
                r_eofSeen <= 1'b1;
            end

            // Issue stops at eof, so r_rdPtr already points just past it.
            if (w_commit) begin
                r_rdPtrOut <= r_rdPtr;
                r_rdPtrUpd <= ~r_rdPtrUpd;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Two-entry output buffer; r_buf0 is the head presented to the MAC.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf0   <= '0;
            r_buf1   <= '0;
            r_bufCnt <= 2'd0;
        end else if (w_retry || w_flush || w_commit) begin
            r_bufCnt <= 2'd0;
        end else begin
            case ({w_push, w_accept})
                2'b10: begin
                    if (r_bufCnt == 2'd0) begin
                        r_buf0 <= rd_data;
                    end else begin
                        r_buf1 <= rd_data;
                    end
                    r_bufCnt <= r_bufCnt + 2'd1;
                end
                2'b01: begin
                    r_buf0   <= r_buf1;
                    r_bufCnt <= r_bufCnt - 2'd1;
                end
                2'b11: begin
                    if (r_bufCnt == 2'd1) begin
                        r_buf0 <= rd_data;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= rd_data;
                    end
                end
                default: begin
                    r_bufCnt <= r_bufCnt;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
